// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint sequence monitor: watches an asynchronous status bus and checks
// that it walks through a programmed list of masked checkpoint values in order,
// with each checkpoint held stable for STABLE cycles and an optional per-step
// timeout. The result is reported as pass, or as fail with a reason code.
module checkpoint_seq_monitor #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int TMR_W  = 24,
  parameter int STABLE = 2
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic [WIDTH-1:0]         mon_bits,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [WIDTH-1:0]         cfg_exp,
  input  logic [WIDTH-1:0]         cfg_mask,
  input  logic [$clog2(DEPTH):0]   cfg_count,
  input  logic [TMR_W-1:0]         tmo_limit,
  input  logic                     start,
  input  logic                     clear,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_code,
  output logic [$clog2(DEPTH):0]   cur_idx,
  output logic                     step_strobe
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = IDXW + 1;
  localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
  localparam logic [3:0]      STABLE_C = 4'(STABLE);

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_CONFIG  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_PASS, ST_FAIL} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  mon_s1_q;
  logic [WIDTH-1:0]  mon_q;
  logic [WIDTH-1:0]  exp_q  [DEPTH];
  logic [WIDTH-1:0]  mask_q [DEPTH];
  logic [CNTW-1:0]   count_q;
  logic [TMR_W-1:0]  tmo_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [3:0]        stab_q;
  logic [CNTW-1:0]   cur_idx_q;
  logic              busy_q;
  logic              pass_q;
  logic              fail_q;
  logic [1:0]        fail_code_q;
  logic              step_strobe_q;

  logic [IDXW-1:0]   sel;
  logic              match;
  logic [3:0]        stab_d;
  logic [TMR_W-1:0]  tmr_d;
  logic              accept;
  logic              last;
  logic              tmo_hit;
  logic              cfg_ok;
  logic              wr_ok;

  assign busy        = busy_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = fail_code_q;
  assign cur_idx     = cur_idx_q;
  assign step_strobe = step_strobe_q;

  // Two-flop synchroniser for the asynchronous status bus.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      mon_s1_q <= '0;
      mon_q    <= '0;
    end else begin
      mon_s1_q <= mon_bits;
      mon_q    <= mon_s1_q;
    end
  end

  // Checkpoint table; writes are only accepted while no sequence is running.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        exp_q[i]  <= '0;
        mask_q[i] <= '1;
      end
    end else if (wr_ok) begin
      exp_q[cfg_idx]  <= cfg_exp;
      mask_q[cfg_idx] <= cfg_mask;
    end
  end

  // Compare against the current entry and derive step decisions.
  always_comb begin
    sel   = cur_idx_q[IDXW-1:0];
    match = ((mon_q ^ exp_q[sel]) & mask_q[sel]) == '0;
    if (!match) begin
      stab_d = '0;
    end else if (stab_q == STABLE_C) begin
      stab_d = STABLE_C;
    end else begin
      stab_d = stab_q + 4'd1;
    end
    accept  = match && (stab_d == STABLE_C);
    last    = (cur_idx_q == count_q - CNTW'(1));
    tmo_hit = (tmo_q != '0) && (tmr_q == tmo_q - TMR_W'(1));
    tmr_d   = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
    cfg_ok  = (cfg_count != '0) && (cfg_count <= DEPTH_C);
    wr_ok   = cfg_we && (state_q != ST_CHECK) && ({1'b0, cfg_idx} < DEPTH_C);
  end

  // Sequence FSM with registered status outputs; clear overrides everything.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      tmo_q         <= '0;
      tmr_q         <= '0;
      stab_q        <= '0;
      cur_idx_q     <= '0;
      busy_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_code_q   <= CODE_NONE;
      step_strobe_q <= 1'b0;
    end else if (clear) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      stab_q        <= '0;
      cur_idx_q     <= '0;
      busy_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_code_q   <= CODE_NONE;
      step_strobe_q <= 1'b0;
    end else begin
      step_strobe_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              count_q   <= cfg_count;
              tmo_q     <= tmo_limit;
              cur_idx_q <= '0;
              tmr_q     <= '0;
              stab_q    <= '0;
              busy_q    <= 1'b1;
              state_q   <= ST_CHECK;
            end else begin
              fail_q      <= 1'b1;
              fail_code_q <= CODE_CONFIG;
              state_q     <= ST_FAIL;
            end
          end
        end
        ST_CHECK: begin
          // Accept is evaluated before timeout so it wins a same-cycle tie.
          if (accept) begin
            step_strobe_q <= 1'b1;
            cur_idx_q     <= cur_idx_q + CNTW'(1);
            stab_q        <= '0;
            tmr_q         <= '0;
            if (last) begin
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
              state_q <= ST_PASS;
            end
          end else if (tmo_hit) begin
            busy_q      <= 1'b0;
            fail_q      <= 1'b1;
            fail_code_q <= CODE_TIMEOUT;
            state_q     <= ST_FAIL;
          end else begin
            stab_q <= stab_d;
            tmr_q  <= tmr_d;
          end
        end
        ST_PASS: state_q <= ST_PASS;
        ST_FAIL: state_q <= ST_FAIL;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Scoreboard bench for checkpoint_seq_monitor: a timeline reference model
// predicts step/pass/fail events with their clock edge, a monitor checks them.
module tb_checkpoint_seq_monitor;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int TMR_W  = 24;
  localparam int STABLE = 2;

  logic             clock;
  logic             resetb;
  logic [WIDTH-1:0] mon_bits;
  logic             cfg_we;
  logic [2:0]       cfg_idx;
  logic [WIDTH-1:0] cfg_exp;
  logic [WIDTH-1:0] cfg_mask;
  logic [3:0]       cfg_count;
  logic [TMR_W-1:0] tmo_limit;
  logic             start;
  logic             clear;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [3:0]       cur_idx;
  logic             step_strobe;

  checkpoint_seq_monitor #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TMR_W(TMR_W), .STABLE(STABLE)
  ) dut (
    .clock(clock), .resetb(resetb), .mon_bits(mon_bits),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_exp(cfg_exp), .cfg_mask(cfg_mask),
    .cfg_count(cfg_count), .tmo_limit(tmo_limit), .start(start), .clear(clear),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
    .cur_idx(cur_idx), .step_strobe(step_strobe)
  );

  // kind: 0 = step accepted, 1 = pass, 2 = fail
  typedef struct {
    int kind;
    int idx;
    int code;
    int at;
  } evt_t;

  evt_t             sb_q[$];
  logic [15:0]      plan[$];
  logic [15:0]      m_exp  [DEPTH];
  logic [15:0]      m_mask [DEPTH];
  int               n_chk = 0;
  int               n_fail = 0;
  int               cyc = 0;
  bit               pp = 0;
  bit               fp = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic see(input int kind);
    evt_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: actual kind=%0d idx=%0d code=%0d cyc=%0d, required none",
               kind, cur_idx, fail_code, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.idx != int'(cur_idx) || e.code != int'(fail_code) || e.at != cyc) begin
        n_fail++;
        $display("FAIL event: actual kind=%0d idx=%0d code=%0d cyc=%0d required kind=%0d idx=%0d code=%0d cyc=%0d",
                 kind, cur_idx, fail_code, cyc, e.kind, e.idx, e.code, e.at);
      end
    end
  endtask

  // Monitor: fires on every output event the DUT presents.
  initial begin
    forever begin
      @(negedge clock);
      if (resetb) begin
        if (step_strobe)  see(0);
        if (pass && !pp)  see(1);
        if (fail && !fp)  see(2);
      end
      pp = pass;
      fp = fail;
    end
  end

  function automatic evt_t mk(input int kind, input int idx, input int code, input int at);
    evt_t e;
    e.kind = kind; e.idx = idx; e.code = code; e.at = at;
    return e;
  endfunction

  // Reference model: start sampled at edge s; the comparison at edge s+r sees
  // the bus value sampled at edge s+r-2, which is plan[r-1].
  task automatic model_run(input int s, input int cnt, input int tmo,
                           output int term_r, output int fst, output int fidx, output int fcode);
    int idx, run, since;
    logic [15:0] v;
    idx = 0; run = 0; since = 0;
    term_r = -1; fst = 1; fidx = 0; fcode = 0;
    if (cnt < 1 || cnt > DEPTH) begin
      sb_q.push_back(mk(2, 0, 2, s));
      term_r = 0; fst = 3; fcode = 2;
      return;
    end
    for (int r = 1; r <= plan.size() - 2; r++) begin
      v = plan[r-1];
      if (((v ^ m_exp[idx]) & m_mask[idx]) == 16'h0) run++;
      else run = 0;
      if (run >= STABLE) begin
        idx++;
        sb_q.push_back(mk(0, idx, 0, s + r));
        run = 0; since = 0;
        if (idx == cnt) begin
          sb_q.push_back(mk(1, idx, 0, s + r));
          term_r = r; fst = 2; fidx = idx;
          return;
        end
      end else if (tmo != 0 && since == tmo - 1) begin
        sb_q.push_back(mk(2, idx, 1, s + r));
        term_r = r; fst = 3; fidx = idx; fcode = 1;
        return;
      end else begin
        since++;
      end
    end
    fidx = idx;
  endtask

  task automatic tbl_wr(input int i, input logic [15:0] e, input logic [15:0] m);
    cfg_we = 1; cfg_idx = 3'(i); cfg_exp = e; cfg_mask = m;
    @(posedge clock); #1;
    cfg_we = 0;
    m_exp[i] = e; m_mask[i] = m;
  endtask

  task automatic seg(input logic [15:0] v, input int n);
    repeat (n) plan.push_back(v);
  endtask

  // Drives plan[] around a start pulse; optional writes land only while the
  // model says the DUT is checking, so they must be dropped.
  task automatic run_scn(input string tag, input int cnt, input int tmo, input bit rnd_wr);
    int s, term_r, fst, fidx, fcode;
    s = cyc + 2;
    model_run(s, cnt, tmo, term_r, fst, fidx, fcode);
    for (int k = 0; k < plan.size(); k++) begin
      mon_bits  = plan[k];
      start     = (k == 1);
      cfg_count = 4'(cnt);
      tmo_limit = 24'(tmo);
      cfg_we    = 0;
      if (rnd_wr && k >= 2 && (term_r < 0 || k <= term_r + 1) && $urandom_range(0, 4) == 0) begin
        cfg_we   = 1;
        cfg_idx  = 3'($urandom);
        cfg_exp  = 16'($urandom);
        cfg_mask = 16'($urandom);
      end
      @(posedge clock); #1;
    end
    start = 0; cfg_we = 0;
    @(negedge clock); #1;
    chk({tag, "_events_drained"}, sb_q.size(), 0);
    chk({tag, "_busy"}, busy, fst == 1);
    chk({tag, "_pass"}, pass, fst == 2);
    chk({tag, "_fail"}, fail, fst == 3);
    chk({tag, "_fail_code"}, fail_code, fcode);
    chk({tag, "_cur_idx"}, cur_idx, fidx);
    sb_q.delete();
  endtask

  task automatic do_clear(input string tag);
    clear = 1;
    @(posedge clock); #1;
    clear = 0;
    chk({tag, "_clr_busy"}, busy, 0);
    chk({tag, "_clr_pass"}, pass, 0);
    chk({tag, "_clr_fail"}, fail, 0);
    chk({tag, "_clr_code"}, fail_code, 0);
    chk({tag, "_clr_idx"}, cur_idx, 0);
  endtask

  task automatic model_tbl_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_exp[i] = 16'h0000;
      m_mask[i] = 16'hFFFF;
    end
  endtask

  initial begin
    int cnt, tmo, p, pc, n, sel;
    logic [15:0] v;
    resetb = 0; mon_bits = '0; cfg_we = 0; cfg_idx = '0; cfg_exp = '0; cfg_mask = '0;
    cfg_count = '0; tmo_limit = '0; start = 0; clear = 0;
    model_tbl_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_idx", cur_idx, 0);
    chk("rst_strobe", step_strobe, 0);
    resetb = 1;
    @(posedge clock); #1;

    // Basic three-step pass
    tbl_wr(0, 16'hAB40, 16'hFFFF);
    tbl_wr(1, 16'hAB41, 16'hFFFF);
    tbl_wr(2, 16'hAB51, 16'hFFFF);
    plan.delete();
    seg(16'hAB40, 10); seg(16'hAB41, 10); seg(16'hAB51, 10); seg(16'h0000, 3);
    run_scn("seq3", 3, 0, 0);
    chk("seq3_pass_const", pass, 1);
    chk("seq3_idx_const", cur_idx, 3);
    do_clear("seq3");

    // Timeout after first accept
    plan.delete();
    seg(16'hAB40, 115);
    run_scn("tmo", 3, 100, 0);
    chk("tmo_fail_const", fail, 1);
    chk("tmo_code_const", fail_code, 1);
    chk("tmo_idx_const", cur_idx, 1);
    do_clear("tmo");

    // Single-cycle glitch must not be accepted
    plan.delete();
    seg(16'hAB40, 4); seg(16'hAB41, 1); seg(16'h0000, 10);
    run_scn("glitch", 3, 0, 0);
    chk("glitch_busy_const", busy, 1);
    chk("glitch_idx_const", cur_idx, 1);
    do_clear("glitch");

    // Masked compare
    tbl_wr(0, 16'h0040, 16'h00FF);
    tbl_wr(1, 16'hFFFF, 16'hFFFF);
    plan.delete();
    seg(16'h1241, 6); seg(16'h1240, 4); seg(16'h0000, 4);
    run_scn("mask", 2, 0, 0);
    chk("mask_idx_const", cur_idx, 1);
    do_clear("mask");

    // Config error
    plan.delete();
    seg(16'h0000, 4);
    run_scn("cfg0", 0, 0, 0);
    chk("cfg0_code_const", fail_code, 2);
    do_clear("cfg0");
    plan.delete();
    seg(16'h0000, 4);
    run_scn("cfg9", 9, 0, 0);
    do_clear("cfg9");

    // Async reset while checking at index 2
    tbl_wr(0, 16'hAB40, 16'hFFFF);
    tbl_wr(1, 16'hAB41, 16'hFFFF);
    tbl_wr(2, 16'hAB51, 16'hFFFF);
    plan.delete();
    seg(16'hAB40, 4); seg(16'hAB41, 6);
    run_scn("prerst", 3, 0, 0);
    #2 resetb = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_idx", cur_idx, 0);
    chk("arst_pass", pass, 0);
    chk("arst_fail", fail, 0);
    chk("arst_strobe", step_strobe, 0);
    model_tbl_reset();
    @(posedge clock); #3;
    resetb = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("postrst_busy", busy, 0);
    end
    @(posedge clock); #1;

    // Randomised sequences, partial table rewrites, dropped writes in CHECK
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          sel = $urandom_range(0, 9);
          v = (sel < 6) ? 16'hFFFF : (sel < 9) ? 16'($urandom) : 16'h0000;
          tbl_wr(i, 16'($urandom), v);
        end
      end
      n = $urandom_range(0, 19);
      cnt = (n == 0) ? 0 : (n == 1) ? 9 : $urandom_range(1, DEPTH);
      tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 30);
      pc = (cnt >= 1 && cnt <= DEPTH) ? cnt : 1;
      p = 0;
      plan.delete();
      while (plan.size() < 70) begin
        n = $urandom_range(1, 4);
        if ($urandom_range(0, 9) < 7) begin
          v = m_exp[p] ^ (16'($urandom) & ~m_mask[p]);
          p = (p + 1) % pc;
        end else begin
          v = 16'($urandom);
        end
        seg(v, n);
      end
      run_scn("rnd", cnt, tmo, 1);
      do_clear("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/checkpoint_seq_monitor.md
CHECKPOINT_SEQ_MONITOR -- requirements
Module: checkpoint_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, width of the monitored status bus.
REQ-002 SHALL have parameter DEPTH, default 8, maximum checkpoints per sequence (2..16).
REQ-003 SHALL have parameter TMR_W, default 24, width of the per-step timeout counter.
REQ-004 SHALL have parameter STABLE, default 2, consecutive matching cycles required to accept a checkpoint (1..15).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clock  in  1  sole clock; resetb  in  1  async active-low reset.
REQ-006 SHALL have mon_bits  in  WIDTH  monitored status bus, asynchronous to the checked sequence source.
REQ-007 SHALL have cfg_we  in  1  checkpoint table write strobe.
REQ-008 SHALL have cfg_idx  in  $clog2(DEPTH)  table entry index.
REQ-009 SHALL have cfg_exp  in  WIDTH  expected value for the entry.
REQ-010 SHALL have cfg_mask  in  WIDTH  compare mask for the entry, 1 = bit compared.
REQ-011 SHALL have cfg_count  in  $clog2(DEPTH)+1  number of active checkpoints, sampled at start.
REQ-012 SHALL have tmo_limit  in  TMR_W  per-step timeout in cycles, 0 = disabled, sampled at start.
REQ-013 SHALL have start  in  1  single-cycle arm pulse; clear  in  1  synchronous return to IDLE.
REQ-014 SHALL have busy  out  1; pass  out  1; fail  out  1; fail_code  out  2; cur_idx  out  $clog2(DEPTH)+1; step_strobe  out  1.

Function
REQ-015 SHALL register mon_bits through two flops before compare; compare latency is 2 cycles from bus change.
REQ-016 SHALL implement FSM states IDLE, CHECK, PASS, FAIL.
REQ-017 IDLE: on start with 1 <= cfg_count <= DEPTH, SHALL latch cfg_count and tmo_limit, clear cur_idx, step timer and stable counter, and enter CHECK.
REQ-018 IDLE: on start with cfg_count == 0 or > DEPTH, SHALL enter FAIL with fail_code = 2 (config error).
REQ-019 CHECK: match = ((mon_q ^ exp[cur_idx]) & mask[cur_idx]) == 0; stable counter SHALL increment on match, clear on mismatch, saturating at STABLE.
REQ-020 CHECK: when the stable counter reaches STABLE, SHALL pulse step_strobe for one cycle, increment cur_idx, and clear stable counter and step timer in the same cycle.
REQ-021 CHECK: when the accepted checkpoint is the last (cur_idx == count-1), SHALL enter PASS next cycle; cur_idx then equals count.
REQ-022 CHECK: a new checkpoint SHALL require fresh STABLE matching cycles even if the bus value already matches the next entry.
REQ-023 Step timer SHALL count cycles in CHECK since last accept; when tmo_limit != 0 and timer == tmo_limit-1 without accept, SHALL enter FAIL with fail_code = 1 (timeout).
REQ-024 Accept and timeout in the same cycle: accept SHALL win.
REQ-025 PASS and FAIL SHALL hold until clear; start in PASS/FAIL SHALL be ignored.
REQ-026 start while in CHECK SHALL be ignored; clear in any state SHALL force IDLE next cycle and zero pass, fail, fail_code, cur_idx; clear wins over start.
REQ-027 cfg_we SHALL write table entry cfg_idx in IDLE/PASS/FAIL only; writes during CHECK SHALL be dropped; cfg_idx >= DEPTH SHALL be ignored.
REQ-028 busy = (state == CHECK); pass = (state == PASS); fail = (state == FAIL); all outputs registered.
REQ-029 Timer SHALL not wrap: with tmo_limit == 0 it SHALL saturate at all-ones.

Reset
REQ-030 resetb low SHALL asynchronously force IDLE, busy=0, pass=0, fail=0, fail_code=0, cur_idx=0, step_strobe=0, counters and sync flops to 0.
REQ-031 Table contents SHALL reset to exp=0, mask=all-ones.
REQ-032 Reset deassertion mid-CHECK SHALL leave the block in IDLE; a new start is required.

Verification
REQ-033 Table {AB40,AB41,AB51}, masks FFFF, count=3, tmo_limit=0; drive AB40, AB41, AB51 each 10 cycles -> three step_strobe pulses, pass=1, cur_idx=3.
REQ-034 Same table, tmo_limit=100; hold AB40 indefinitely -> fail=1, fail_code=1, cur_idx=1 exactly 100 cycles after first accept.
REQ-035 STABLE=2; single-cycle glitch AB41 between AB40 and 0000 -> no accept at idx 1, busy stays 1.
REQ-036 Mask 00FF on entry 0, exp 0040; bus 1240 -> accepted; bus 1241 -> not accepted.
REQ-037 start with cfg_count=0 -> fail=1, fail_code=2 next cycle; clear -> IDLE, all status 0.
REQ-038 resetb pulsed low while busy at cur_idx=2 -> outputs 0 immediately; after release, busy=0 until next start.
